// File: rtl/uart_rx_bit_timer_if.sv
// Bundle of the timing-engine signals shared between the RX FSM side
// (master: drives Enable, config and the serial line) and the timer
// (slave: produces counters, sampler output and strobes).
interface uart_rx_bit_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int BITCNT_W   = 4
);
  logic                  Enable;
  logic [PRESCALE_W-1:0] Prescale;
  logic [BITCNT_W-1:0]   Frame_bits;
  logic                  Rx_in;
  logic [PRESCALE_W-1:0] Edge_count;
  logic [BITCNT_W-1:0]   Bit_count;
  logic                  Sampled_bit;
  logic                  Sampled_valid;
  logic                  Bit_done;
  logic                  Frame_done;
  logic                  Cfg_err;

  modport master (
    output Enable, Prescale, Frame_bits, Rx_in,
    input  Edge_count, Bit_count, Sampled_bit, Sampled_valid,
           Bit_done, Frame_done, Cfg_err
  );

  modport slave (
    input  Enable, Prescale, Frame_bits, Rx_in,
    output Edge_count, Bit_count, Sampled_bit, Sampled_valid,
           Bit_done, Frame_done, Cfg_err
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// UART receiver edge/bit timing engine.
// Counts clocks inside a bit period and bit periods inside a frame, takes
// three samples around the bit centre and majority-votes them, and issues
// one-cycle registered strobes for sample, bit and frame completion.
// Prescale/Frame_bits are latched whenever the engine is idle (Rst or
// Enable low), so configuration changes during a frame have no effect.
module uart_rx_bit_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BITCNT_W   = 4
) (
  input logic                 Clk,
  input logic                 Rst,
  uart_rx_bit_timer_if.slave  bus
);

  // Smallest legal settings: prescale 4 keeps the three sample points
  // strictly inside the bit, frame length 2 is start plus one more bit.
  localparam logic [PRESCALE_W-1:0] P_MIN  = PRESCALE_W'(4);
  localparam logic [BITCNT_W-1:0]   F_MIN  = BITCNT_W'(2);
  localparam logic [PRESCALE_W-1:0] E_ONE  = PRESCALE_W'(1);
  localparam logic [BITCNT_W-1:0]   B_ONE  = BITCNT_W'(1);

  // Two-out-of-three vote over the samples taken around the bit centre.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Latched configuration.
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [BITCNT_W-1:0]   f_q, f_d;

  // Counters.
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BITCNT_W-1:0]   bit_q, bit_d;

  // Vote samples and registered outputs.
  logic s0_q, s0_d;
  logic s1_q, s1_d;
  logic sbit_q, sbit_d;
  logic sval_q, sval_d;
  logic bdone_q, bdone_d;
  logic fdone_q, fdone_d;

  // Decoded timing points.
  logic                  cfg_err_s;
  logic [PRESCALE_W-1:0] mid_s;
  logic [PRESCALE_W-1:0] mid_m1_s;
  logic [PRESCALE_W-1:0] mid_p1_s;
  logic [PRESCALE_W-1:0] edge_max_s;
  logic [BITCNT_W-1:0]   bit_max_s;
  logic                  edge_last_s;
  logic                  bit_last_s;

  // Configuration legality and the positions inside the bit that matter.
  always_comb begin
    cfg_err_s   = (p_q < P_MIN) | (f_q < F_MIN);
    mid_s       = p_q >> 1;
    mid_m1_s    = mid_s - E_ONE;
    mid_p1_s    = mid_s + E_ONE;
    edge_max_s  = p_q - E_ONE;
    bit_max_s   = f_q - B_ONE;
    edge_last_s = (edge_q == edge_max_s);
    bit_last_s  = (bit_q == bit_max_s);
  end

  // Config registers reload while idle and freeze once counting starts.
  always_comb begin
    if (!bus.Enable) begin
      p_d = bus.Prescale;
      f_d = bus.Frame_bits;
    end else begin
      p_d = p_q;
      f_d = f_q;
    end
  end

  // Next state of counters, sampler and strobes.
  always_comb begin
    edge_d  = '0;
    bit_d   = '0;
    s0_d    = 1'b0;
    s1_d    = 1'b0;
    sbit_d  = sbit_q;
    sval_d  = 1'b0;
    bdone_d = 1'b0;
    fdone_d = 1'b0;
    if (!bus.Enable) begin
      // Idle: everything cleared, any half-finished vote is dropped.
      sbit_d = 1'b0;
    end else if (cfg_err_s) begin
      // Illegal configuration: engine parked with counters and strobes at 0.
      sbit_d = sbit_q;
    end else begin
      // Clock position inside the bit.
      if (edge_last_s) begin
        edge_d = '0;
      end else begin
        edge_d = edge_q + E_ONE;
      end
      // Bit position inside the frame; advances only at the bit boundary.
      if (edge_last_s) begin
        if (bit_last_s) begin
          bit_d = '0;
        end else begin
          bit_d = bit_q + B_ONE;
        end
      end else begin
        bit_d = bit_q;
      end
      // Samples just before and at the centre are held for the vote.
      if (edge_q == mid_m1_s) begin
        s0_d = bus.Rx_in;
      end else begin
        s0_d = s0_q;
      end
      if (edge_q == mid_s) begin
        s1_d = bus.Rx_in;
      end else begin
        s1_d = s1_q;
      end
      // Third sample just after the centre completes the vote.
      if (edge_q == mid_p1_s) begin
        sbit_d = majority3(s0_q, s1_q, bus.Rx_in);
        sval_d = 1'b1;
      end else begin
        sbit_d = sbit_q;
        sval_d = 1'b0;
      end
      bdone_d = edge_last_s;
      fdone_d = edge_last_s & bit_last_s;
    end
  end

  // State update; Rst clears everything and also latches the config.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      p_q     <= bus.Prescale;
      f_q     <= bus.Frame_bits;
      edge_q  <= '0;
      bit_q   <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      sbit_q  <= 1'b0;
      sval_q  <= 1'b0;
      bdone_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      f_q     <= f_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      sbit_q  <= sbit_d;
      sval_q  <= sval_d;
      bdone_q <= bdone_d;
      fdone_q <= fdone_d;
    end
  end

  assign bus.Edge_count    = edge_q;
  assign bus.Bit_count     = bit_q;
  assign bus.Sampled_bit   = sbit_q;
  assign bus.Sampled_valid = sval_q;
  assign bus.Bit_done      = bdone_q;
  assign bus.Frame_done    = fdone_q;
  assign bus.Cfg_err       = cfg_err_s;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: a cycle model pushes the
// expected outputs into a scoreboard queue as each stimulus cycle is
// driven; each scenario task pops and compares after the clock edge and
// adds its own scenario-specific checks.
module tb_uart_rx_bit_timer;

  typedef struct packed {
    logic [5:0] ec;
    logic [3:0] bc;
    logic       sb;
    logic       sv;
    logic       bd;
    logic       fd;
    logic       ce;
  } obs_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  obs_t sb_q[$];

  // Model state.
  int m_p, m_f, m_edge, m_bit, m_s0, m_s1, m_sbit, m_sval, m_bd, m_fd;

  uart_rx_bit_timer_if #(.PRESCALE_W(6), .BITCNT_W(4)) bus_if();

  uart_rx_bit_timer #(.PRESCALE_W(6), .BITCNT_W(4)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample_dut();
    obs_t o;
    o.ec = bus_if.Edge_count;
    o.bc = bus_if.Bit_count;
    o.sb = bus_if.Sampled_bit;
    o.sv = bus_if.Sampled_valid;
    o.bd = bus_if.Bit_done;
    o.fd = bus_if.Frame_done;
    o.ce = bus_if.Cfg_err;
    return o;
  endfunction

  // Drive one cycle of stimulus, advance the model, queue the expectation.
  task automatic drive_cycle(input logic r, input logic en, input logic [5:0] ps,
                             input logic [3:0] fb, input logic rx);
    obs_t e;
    int   mid;
    bit   last, flast;
    rst               = r;
    bus_if.Enable     = en;
    bus_if.Prescale   = ps;
    bus_if.Frame_bits = fb;
    bus_if.Rx_in      = rx;
    if (r || !en) begin
      m_p = int'(ps); m_f = int'(fb);
      m_edge = 0; m_bit = 0; m_s0 = 0; m_s1 = 0;
      m_sbit = 0; m_sval = 0; m_bd = 0; m_fd = 0;
    end else if (m_p < 4 || m_f < 2) begin
      m_edge = 0; m_bit = 0; m_s0 = 0; m_s1 = 0;
      m_sval = 0; m_bd = 0; m_fd = 0;
    end else begin
      mid   = m_p / 2;
      last  = (m_edge == m_p - 1);
      flast = (m_bit == m_f - 1);
      m_sval = (m_edge == mid + 1) ? 1 : 0;
      if (m_sval == 1) m_sbit = (m_s0 + m_s1 + int'(rx) >= 2) ? 1 : 0;
      if (m_edge == mid - 1) m_s0 = int'(rx);
      if (m_edge == mid) m_s1 = int'(rx);
      m_bd = last ? 1 : 0;
      m_fd = (last && flast) ? 1 : 0;
      if (last) begin
        m_edge = 0;
        m_bit  = flast ? 0 : m_bit + 1;
      end else begin
        m_edge = m_edge + 1;
      end
    end
    e.ec = 6'(m_edge);
    e.bc = 4'(m_bit);
    e.sb = 1'(m_sbit);
    e.sv = 1'(m_sval);
    e.bd = 1'(m_bd);
    e.fd = 1'(m_fd);
    e.ce = (m_p < 4 || m_f < 2) ? 1'b1 : 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp_v;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 6'd8, 4'd10, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL reset_sb cyc%0d: got %h want %h", i, got, exp_v);
      end
      n_cmp++;
      if (got !== 15'h0) begin
        n_err++; $display("FAIL reset_zero cyc%0d: got %h want 0", i, got);
      end
    end
  endtask

  task automatic test_nominal();
    obs_t got, exp_v;
    int   n_fd;
    n_fd = 0;
    drive_cycle(1'b0, 1'b0, 6'd8, 4'd10, 1'b1);
    got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL nominal_latch: got %h want %h", got, exp_v); end
    for (int i = 0; i < 160; i++) begin
      drive_cycle(1'b0, 1'b1, 6'd8, 4'd10, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL nominal_sb cyc%0d: got %h want %h", i, got, exp_v); end
      if (got.sv === 1'b1) begin
        n_cmp++;
        if (got.ec !== 6'd6 || got.sb !== 1'b1) begin
          n_err++; $display("FAIL nominal_sample: ec=%0d sb=%b want ec=6 sb=1", got.ec, got.sb);
        end
      end
      if (got.fd === 1'b1) begin
        n_fd++; n_cmp++;
        if (got.bd !== 1'b1 || got.ec !== 6'd0 || got.bc !== 4'd0) begin
          n_err++; $display("FAIL back_to_back: bd=%b ec=%0d bc=%0d want 1/0/0", got.bd, got.ec, got.bc);
        end
      end
    end
    n_cmp++;
    if (n_fd != 2) begin n_err++; $display("FAIL nominal_frames: got %0d want 2", n_fd); end
  endtask

  task automatic test_glitch_vote();
    obs_t got, exp_v;
    logic rx;
    int   n_sv;
    drive_cycle(1'b0, 1'b0, 6'd8, 4'd10, 1'b1);
    got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL glitch_latch: got %h want %h", got, exp_v); end
    for (int pat = 0; pat < 2; pat++) begin
      n_sv = 0;
      for (int i = 0; i < 24; i++) begin
        if (pat == 0) rx = (m_edge == 4) ? 1'b0 : 1'b1;
        else          rx = (m_edge == 3 || m_edge == 4) ? 1'b0 : 1'b1;
        drive_cycle(1'b0, 1'b1, 6'd8, 4'd10, rx);
        got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL glitch_sb p%0d c%0d: got %h want %h", pat, i, got, exp_v); end
        if (got.sv === 1'b1) begin
          n_sv++; n_cmp++;
          if (got.sb !== ((pat == 0) ? 1'b1 : 1'b0)) begin
            n_err++; $display("FAIL glitch_vote p%0d: got %b want %0d", pat, got.sb, (pat == 0) ? 1 : 0);
          end
        end
      end
      n_cmp++;
      if (n_sv != 3) begin n_err++; $display("FAIL glitch_pulses p%0d: got %0d want 3", pat, n_sv); end
    end
  endtask

  task automatic test_config_change();
    obs_t got, exp_v;
    int   n_fd, n_bd, max_ec;
    drive_cycle(1'b0, 1'b0, 6'd5, 4'd2, 1'b0);
    got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL cfg_latch: got %h want %h", got, exp_v); end
    n_fd = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 1'b1, 6'd5, 4'd2, 1'(i % 3 == 0));
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL cfg_sb5 c%0d: got %h want %h", i, got, exp_v); end
      if (got.fd === 1'b1) n_fd++;
      if (got.sv === 1'b1) begin
        n_cmp++;
        if (got.ec !== 6'd4) begin n_err++; $display("FAIL cfg_sample5: ec=%0d want 4", got.ec); end
      end
    end
    n_cmp++;
    if (n_fd != 2) begin n_err++; $display("FAIL cfg_frames5: got %0d want 2", n_fd); end
    n_bd = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b1, 6'd16, 4'd2, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL cfg_hold c%0d: got %h want %h", i, got, exp_v); end
      if (got.bd === 1'b1) n_bd++;
    end
    n_cmp++;
    if (n_bd != 2) begin n_err++; $display("FAIL cfg_ignored: bit_done %0d want 2", n_bd); end
    drive_cycle(1'b0, 1'b0, 6'd16, 4'd2, 1'b1);
    got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL cfg_relatch: got %h want %h", got, exp_v); end
    n_bd = 0; max_ec = 0;
    for (int i = 0; i < 32; i++) begin
      drive_cycle(1'b0, 1'b1, 6'd16, 4'd2, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL cfg_sb16 c%0d: got %h want %h", i, got, exp_v); end
      if (got.bd === 1'b1) n_bd++;
      if (int'(got.ec) > max_ec) max_ec = int'(got.ec);
    end
    n_cmp++;
    if (n_bd != 2 || max_ec != 15) begin
      n_err++; $display("FAIL cfg_new16: bit_done %0d max_ec %0d want 2 and 15", n_bd, max_ec);
    end
  endtask

  task automatic test_enable_drop();
    obs_t got, exp_v;
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, 1'b0, 6'd8, 4'd10, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL drop_latch k%0d: got %h want %h", k, got, exp_v); end
      for (int i = 0; i < ((k == 0) ? 35 : 13); i++) begin
        drive_cycle(1'b0, 1'b1, 6'd8, 4'd10, 1'b1);
        got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL drop_sb k%0d c%0d: got %h want %h", k, i, got, exp_v); end
      end
      n_cmp++;
      if (got.ec !== ((k == 0) ? 6'd3 : 6'd5) || got.bc !== ((k == 0) ? 4'd4 : 4'd1)) begin
        n_err++; $display("FAIL drop_pos k%0d: ec=%0d bc=%0d", k, got.ec, got.bc);
      end
      drive_cycle(1'b0, 1'b0, 6'd8, 4'd10, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL drop_sb_off k%0d: got %h want %h", k, got, exp_v); end
      n_cmp++;
      if (got.ec !== 6'd0 || got.bc !== 4'd0 || got.sv !== 1'b0 || got.bd !== 1'b0) begin
        n_err++; $display("FAIL drop_clear k%0d: got %h want counters/strobes 0", k, got);
      end
      drive_cycle(1'b0, 1'b1, 6'd8, 4'd10, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL drop_sb_on k%0d: got %h want %h", k, got, exp_v); end
      n_cmp++;
      if (got.ec !== 6'd1 || got.bc !== 4'd0) begin
        n_err++; $display("FAIL drop_restart k%0d: ec=%0d bc=%0d want 1/0", k, got.ec, got.bc);
      end
    end
  endtask

  task automatic test_cfg_err();
    obs_t got, exp_v;
    logic [5:0] ps;
    logic [3:0] fb;
    int   bad, max_ec, n_bd;
    for (int k = 0; k < 2; k++) begin
      ps = (k == 0) ? 6'd3 : 6'd8;
      fb = (k == 0) ? 4'd10 : 4'd1;
      bad = 0;
      drive_cycle(1'b0, 1'b0, ps, fb, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL cerr_latch k%0d: got %h want %h", k, got, exp_v); end
      for (int i = 0; i < 50; i++) begin
        drive_cycle(1'b0, 1'b1, ps, fb, 1'(i % 2));
        got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin n_err++; $display("FAIL cerr_sb k%0d c%0d: got %h want %h", k, i, got, exp_v); end
        if (got !== 15'h1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL cerr_parked k%0d: %0d bad cycles want 0", k, bad); end
    end
    drive_cycle(1'b0, 1'b0, 6'd63, 4'd15, 1'b1);
    got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL max_latch: got %h want %h", got, exp_v); end
    max_ec = 0; n_bd = 0;
    for (int i = 0; i < 131; i++) begin
      drive_cycle(1'b0, 1'b1, 6'd63, 4'd15, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL max_sb c%0d: got %h want %h", i, got, exp_v); end
      if (int'(got.ec) > max_ec) max_ec = int'(got.ec);
      if (got.bd === 1'b1) n_bd++;
    end
    n_cmp++;
    if (max_ec != 62 || n_bd != 2) begin
      n_err++; $display("FAIL max_wrap: max_ec %0d bit_done %0d want 62 and 2", max_ec, n_bd);
    end
  endtask

  task automatic test_reset_priority();
    obs_t got, exp_v;
    drive_cycle(1'b0, 1'b0, 6'd8, 4'd10, 1'b1);
    got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL rprio_latch: got %h want %h", got, exp_v); end
    for (int i = 0; i < 61; i++) begin
      drive_cycle(1'b0, 1'b1, 6'd8, 4'd10, 1'(i % 5 != 0));
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rprio_sb c%0d: got %h want %h", i, got, exp_v); end
    end
    n_cmp++;
    if (got.ec !== 6'd5 || got.bc !== 4'd7) begin
      n_err++; $display("FAIL rprio_pos: ec=%0d bc=%0d want 5/7", got.ec, got.bc);
    end
    drive_cycle(1'b1, 1'b1, 6'd8, 4'd10, 1'b1);
    got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL rprio_sb_rst: got %h want %h", got, exp_v); end
    n_cmp++;
    if (got !== 15'h0) begin n_err++; $display("FAIL rprio_clear: got %h want 0", got); end
    drive_cycle(1'b0, 1'b1, 6'd8, 4'd10, 1'b1);
    got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
    if (got.ec !== 6'd1 || got !== exp_v) begin
      n_err++; $display("FAIL rprio_resume: got %h want %h", got, exp_v);
    end
  endtask

  task automatic test_random();
    obs_t got, exp_v;
    logic [5:0] ps;
    logic [3:0] fb;
    for (int r = 0; r < 4; r++) begin
      ps = 6'($urandom_range(20, 4));
      fb = 4'($urandom_range(12, 2));
      drive_cycle(1'b0, 1'b0, ps, fb, 1'b1);
      got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rand_latch r%0d: got %h want %h", r, got, exp_v); end
      for (int i = 0; i < 150; i++) begin
        drive_cycle(1'b0, 1'b1, ps, fb, 1'($urandom_range(1, 0)));
        got = sample_dut(); exp_v = sb_q.pop_front(); n_cmp++;
        if (got !== exp_v) begin
          n_err++; $display("FAIL rand_sb r%0d c%0d P=%0d F=%0d: got %h want %h", r, i, ps, fb, got, exp_v);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.Enable = 1'b0;
    bus_if.Prescale = 6'd8;
    bus_if.Frame_bits = 4'd10;
    bus_if.Rx_in = 1'b1;
    #1;
    test_reset();
    test_nominal();
    test_glitch_vote();
    test_config_change();
    test_enable_drop();
    test_cfg_err();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
